// File: rtl/multi_counter_lat_pkg.sv
// Shared types for the multi-channel counter: overflow policy, per-channel
// operation encoding and the priority resolver that picks one op per cycle.
package counter_pkg;

  localparam int MAX_LATENCY = 8;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_CLR  = 3'd1,
    OP_SET  = 3'd2,
    OP_INC  = 3'd3,
    OP_DEC  = 3'd4
  } cnt_op_e;

  // inc and dec together cancel out, so they resolve to a hold
  function automatic cnt_op_e resolve_op(input logic clr, input logic setv,
                                         input logic inc, input logic dec);
    cnt_op_e op;
    op = OP_HOLD;
    if (clr)              op = OP_CLR;
    else if (setv)        op = OP_SET;
    else if (inc && !dec) op = OP_INC;
    else if (dec && !inc) op = OP_DEC;
    return op;
  endfunction

endpackage

// File: rtl/multi_counter_lat_if.sv
// Flattened per-channel operation and result buses of the multi-channel counter.
interface multi_counter_lat_if #(
  parameter int NUM_CH = 3,
  parameter int WIDTH  = 13,
  parameter int STEP_W = 4
);
  logic [NUM_CH-1:0]        inc;
  logic [NUM_CH-1:0]        dec;
  logic [NUM_CH*STEP_W-1:0] step;
  logic [NUM_CH-1:0]        set_val_vld;
  logic [NUM_CH*WIDTH-1:0]  set_val;
  logic [NUM_CH-1:0]        clear;
  logic [NUM_CH*WIDTH-1:0]  dout;
  logic [NUM_CH-1:0]        ovf;
  logic [NUM_CH-1:0]        unf;

  modport master (
    output inc, dec, step, set_val_vld, set_val, clear,
    input  dout, ovf, unf
  );

  modport slave (
    input  inc, dec, step, set_val_vld, set_val, clear,
    output dout, ovf, unf
  );
endinterface

// File: rtl/multi_counter_lat_lane.sv
// One counter channel: op decode, add/sub with wrap or clamp, counter register
// and a delay line carrying {value, ovf, unf} to the outputs.
module counter_lane
  import counter_pkg::*;
#(
  parameter int        WIDTH   = 13,
  parameter int        STEP_W  = 4,
  parameter int        LATENCY = 1,
  parameter cnt_mode_e MODE    = CNT_WRAP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_inc,
  input  logic              i_dec,
  input  logic [STEP_W-1:0] i_step,
  input  logic              i_set_vld,
  input  logic [WIDTH-1:0]  i_set_val,
  input  logic              i_clear,
  output logic [WIDTH-1:0]  o_dout,
  output logic              o_ovf,
  output logic              o_unf
);

  localparam int              PW      = WIDTH + 2;
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("counter_lane: LATENCY out of range");
  end

  logic [WIDTH-1:0] r_cnt;
  logic             r_ovf;
  logic             r_unf;

  cnt_op_e          w_op;
  logic [WIDTH:0]   w_step_ext;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_nxt;
  logic             w_ovf;
  logic             w_unf;

  assign w_op       = resolve_op(i_clear, i_set_vld, i_inc, i_dec);
  assign w_step_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, i_step};
  // The extra MSB is the carry for inc and the borrow for dec
  assign w_sum      = {1'b0, r_cnt} + w_step_ext;
  assign w_diff     = {1'b0, r_cnt} - w_step_ext;

  always_comb begin
    w_nxt = r_cnt;
    w_ovf = 1'b0;
    w_unf = 1'b0;
    case (w_op)
      OP_CLR: w_nxt = '0;
      OP_SET: w_nxt = i_set_val;
      OP_INC: begin
        w_nxt = w_sum[WIDTH-1:0];
        if (w_sum[WIDTH]) begin
          w_ovf = 1'b1;
          if (MODE == CNT_SAT) w_nxt = CNT_MAX;
        end
      end
      OP_DEC: begin
        w_nxt = w_diff[WIDTH-1:0];
        if (w_diff[WIDTH]) begin
          w_unf = 1'b1;
          if (MODE == CNT_SAT) w_nxt = '0;
        end
      end
      default: w_nxt = r_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_cnt <= w_nxt;
      r_ovf <= w_ovf;
      r_unf <= w_unf;
    end
  end

  if (LATENCY == 1) begin : g_direct
    assign o_dout = r_cnt;
    assign o_ovf  = r_ovf;
    assign o_unf  = r_unf;
  end else begin : g_pipe
    logic [PW-1:0] r_pipe [LATENCY-1];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < LATENCY - 1; i++) r_pipe[i] <= '0;
      end else begin
        r_pipe[0] <= {r_cnt, r_ovf, r_unf};
        for (int i = 1; i < LATENCY - 1; i++) r_pipe[i] <= r_pipe[i-1];
      end
    end

    assign {o_dout, o_ovf, o_unf} = r_pipe[LATENCY-2];
  end

endmodule

// File: rtl/multi_counter_lat.sv
// Multi-channel counter with configurable output latency; each channel is an
// independent counter_lane sliced out of the flattened interface buses.
module multi_counter_lat
  import counter_pkg::*;
#(
  parameter int        NUM_CH  = 3,
  parameter int        WIDTH   = 13,
  parameter int        STEP_W  = 4,
  parameter int        LATENCY = 1,
  parameter cnt_mode_e MODE    = CNT_WRAP
) (
  input  logic               clk,
  input  logic               rst,
  multi_counter_lat_if.slave bus
);

  logic [NUM_CH*WIDTH-1:0] w_dout;
  logic [NUM_CH-1:0]       w_ovf;
  logic [NUM_CH-1:0]       w_unf;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    counter_lane #(
      .WIDTH  (WIDTH),
      .STEP_W (STEP_W),
      .LATENCY(LATENCY),
      .MODE   (MODE)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .i_inc    (bus.inc[g]),
      .i_dec    (bus.dec[g]),
      .i_step   (bus.step[g*STEP_W +: STEP_W]),
      .i_set_vld(bus.set_val_vld[g]),
      .i_set_val(bus.set_val[g*WIDTH +: WIDTH]),
      .i_clear  (bus.clear[g]),
      .o_dout   (w_dout[g*WIDTH +: WIDTH]),
      .o_ovf    (w_ovf[g]),
      .o_unf    (w_unf[g])
    );
  end

  assign bus.dout = w_dout;
  assign bus.ovf  = w_ovf;
  assign bus.unf  = w_unf;

endmodule

// File: tb/tb_multi_counter_lat.sv
// Scoreboard bench: three instances (wrap/L3, sat/L3, wrap/L1) share one stimulus
// stream; an arithmetic reference model feeds per-instance expectation queues.
module tb_multi_counter_lat;
  import counter_pkg::*;

  localparam int NC = 2;
  localparam int W  = 8;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NC-1:0]    s_inc, s_dec, s_setv, s_clr;
  logic [NC*SW-1:0] s_step;
  logic [NC*W-1:0]  s_setval;

  multi_counter_lat_if #(.NUM_CH(NC), .WIDTH(W), .STEP_W(SW)) if_w3 ();
  multi_counter_lat_if #(.NUM_CH(NC), .WIDTH(W), .STEP_W(SW)) if_s3 ();
  multi_counter_lat_if #(.NUM_CH(NC), .WIDTH(W), .STEP_W(SW)) if_w1 ();

  assign if_w3.inc = s_inc;   assign if_w3.dec = s_dec;   assign if_w3.step = s_step;
  assign if_w3.set_val_vld = s_setv; assign if_w3.set_val = s_setval; assign if_w3.clear = s_clr;
  assign if_s3.inc = s_inc;   assign if_s3.dec = s_dec;   assign if_s3.step = s_step;
  assign if_s3.set_val_vld = s_setv; assign if_s3.set_val = s_setval; assign if_s3.clear = s_clr;
  assign if_w1.inc = s_inc;   assign if_w1.dec = s_dec;   assign if_w1.step = s_step;
  assign if_w1.set_val_vld = s_setv; assign if_w1.set_val = s_setval; assign if_w1.clear = s_clr;

  multi_counter_lat #(.NUM_CH(NC), .WIDTH(W), .STEP_W(SW), .LATENCY(3), .MODE(CNT_WRAP))
    dut_w3 (.clk(clk), .rst(rst), .bus(if_w3));
  multi_counter_lat #(.NUM_CH(NC), .WIDTH(W), .STEP_W(SW), .LATENCY(3), .MODE(CNT_SAT))
    dut_s3 (.clk(clk), .rst(rst), .bus(if_s3));
  multi_counter_lat #(.NUM_CH(NC), .WIDTH(W), .STEP_W(SW), .LATENCY(1), .MODE(CNT_WRAP))
    dut_w1 (.clk(clk), .rst(rst), .bus(if_w1));

  // Expected entries are {dout[15:0], ovf[1:0], unf[1:0]}
  logic [19:0] q_w3[$];
  logic [19:0] q_s3[$];
  logic [19:0] q_w1[$];
  int cw[NC];
  int cs[NC];
  int errors = 0;
  int checks = 0;

  function automatic void model_step(input bit sat, input int cnt_in, input bit clr,
                                     input bit setv, input bit inc, input bit dec,
                                     input int stp, input int sv,
                                     output int cnt_out, output bit o, output bit u);
    cnt_out = cnt_in;
    o = 1'b0;
    u = 1'b0;
    if (clr) cnt_out = 0;
    else if (setv) cnt_out = sv;
    else if (inc && !dec) begin
      if (cnt_in + stp > 255) begin
        o = 1'b1;
        cnt_out = sat ? 255 : cnt_in + stp - 256;
      end else cnt_out = cnt_in + stp;
    end else if (dec && !inc) begin
      if (stp > cnt_in) begin
        u = 1'b1;
        cnt_out = sat ? 0 : cnt_in - stp + 256;
      end else cnt_out = cnt_in - stp;
    end
  endfunction

  int          m_n;
  bit          m_o, m_u;
  logic [19:0] m_ew, m_es;

  always @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NC; c++) begin
        cw[c] = 0;
        cs[c] = 0;
      end
      // a flushed pipeline shows zeros until post-reset ops reach the output
      q_w3.delete(); q_s3.delete(); q_w1.delete();
      repeat (3) begin q_w3.push_back('0); q_s3.push_back('0); end
      q_w1.push_back('0);
    end else begin
      m_ew = '0;
      m_es = '0;
      for (int c = 0; c < NC; c++) begin
        model_step(1'b0, cw[c], s_clr[c], s_setv[c], s_inc[c], s_dec[c],
                   int'(s_step[c*SW +: SW]), int'(s_setval[c*W +: W]), m_n, m_o, m_u);
        cw[c] = m_n;
        m_ew[4 + c*8 +: 8] = m_n[7:0];
        m_ew[2 + c] = m_o;
        m_ew[c] = m_u;
        model_step(1'b1, cs[c], s_clr[c], s_setv[c], s_inc[c], s_dec[c],
                   int'(s_step[c*SW +: SW]), int'(s_setval[c*W +: W]), m_n, m_o, m_u);
        cs[c] = m_n;
        m_es[4 + c*8 +: 8] = m_n[7:0];
        m_es[2 + c] = m_o;
        m_es[c] = m_u;
      end
      q_w3.push_back(m_ew);
      q_s3.push_back(m_es);
      q_w1.push_back(m_ew);
    end
  end

  task automatic check(input string nm, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: {dout,ovf,unf} got %h expected %h", nm, $time, act, exp);
    end
  endtask

  logic [19:0] e;
  always @(negedge clk) begin
    if (q_w3.size() >= 3) begin
      e = q_w3.pop_front();
      check("wrap_lat3", {if_w3.dout, if_w3.ovf, if_w3.unf}, e);
    end
    if (q_s3.size() >= 3) begin
      e = q_s3.pop_front();
      check("sat_lat3", {if_s3.dout, if_s3.ovf, if_s3.unf}, e);
    end
    if (q_w1.size() >= 1) begin
      e = q_w1.pop_front();
      check("wrap_lat1", {if_w1.dout, if_w1.ovf, if_w1.unf}, e);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    s_inc = '0; s_dec = '0; s_setv = '0; s_clr = '0; s_step = '0; s_setval = '0;
  endtask

  task automatic drive(input int ch, input bit clr, input bit setv, input bit inc,
                       input bit dec, input int stp, input int sv);
    s_clr[ch]  = clr;
    s_setv[ch] = setv;
    s_inc[ch]  = inc;
    s_dec[ch]  = dec;
    s_step[ch*SW +: SW]  = SW'(stp);
    s_setval[ch*W +: W]  = W'(sv);
  endtask

  int r;
  int pick;

  initial begin
    s_inc = '0; s_dec = '0; s_setv = '0; s_clr = '0; s_step = '0; s_setval = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // back-to-back increments on ch0
    for (int i = 0; i < 5; i++) begin drive(0, 0, 0, 1, 0, 1, 0); tick(); end
    tick(); tick();

    // wrap through max, then borrow through zero
    drive(0, 0, 1, 0, 0, 0, 8'hFE); tick();
    drive(0, 0, 0, 1, 0, 3, 0);     tick();
    drive(0, 0, 0, 0, 1, 2, 0);     tick();

    // clamp at the limits on ch1
    drive(1, 0, 1, 0, 0, 0, 8'hFD); tick();
    drive(1, 0, 0, 1, 0, 5, 0);     tick();
    drive(1, 0, 0, 1, 0, 5, 0);     tick();
    drive(1, 1, 0, 0, 0, 0, 0);     tick();
    drive(1, 0, 0, 0, 1, 1, 0);     tick();
    drive(1, 0, 0, 0, 1, 1, 0);     tick();

    // priority resolution, step of zero
    drive(0, 1, 1, 1, 0, 2, 8'h55); tick();
    drive(0, 0, 1, 1, 0, 2, 8'h55); tick();
    drive(0, 0, 0, 1, 1, 7, 0);     tick();
    drive(0, 0, 0, 1, 0, 0, 0);     tick();
    drive(0, 0, 0, 0, 1, 0, 0);     tick();

    // reset with values still in flight
    drive(0, 0, 1, 0, 0, 0, 8'hA5); drive(1, 0, 1, 0, 0, 0, 8'h3C); tick();
    drive(0, 0, 0, 1, 0, 4, 0);     tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    repeat (4) tick();

    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < NC; c++) begin
        r = $urandom_range(0, 15);
        pick = $urandom_range(0, 5);
        drive(c, r == 0, (r == 1) || (r == 2), $urandom_range(0, 1) == 1,
              $urandom_range(0, 2) == 0, $urandom_range(0, 15),
              (pick == 0) ? 0 : (pick == 1) ? 255 : (pick == 2) ? 254 : $urandom_range(0, 255));
      end
      rst = ($urandom_range(0, 99) == 0);
      tick();
      rst = 1'b0;
    end

    repeat (5) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_counter_lat.md
Name: multi_counter_lat

Overview:
Parametrised, multi-channel successor to the single accumulator-based counter used by the BRAM FIFO pointer logic. Each channel holds an independent WIDTH-bit counter with clear, load, and up/down-by-step operations. The block selects wrap or saturate overflow handling. The output view is delayed by a configurable register pipeline, so FIFO pointer and occupancy logic can trade latency for timing without losing back-to-back updates. One instance sits in the FIFO controller and serves write pointer, read pointer and occupancy as separate channels.

Parameters:
NUM_CH, 3, number of independent counter channels (>=1)
WIDTH, 13, counter width in bits (2..32)
STEP_W, 4, width of the per-channel step operand (1..WIDTH)
LATENCY, 1, output pipeline depth in cycles (1..8); 1 = counter register drives dout directly
MODE, CNT_WRAP, overflow policy from counter_pkg: CNT_WRAP (modulo 2^WIDTH) or CNT_SAT (clamp)

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
inc  in  NUM_CH  per-channel: add step this cycle
dec  in  NUM_CH  per-channel: subtract step this cycle
step  in  NUM_CH*STEP_W  per-channel step magnitude, zero-extended to WIDTH
set_val_vld  in  NUM_CH  per-channel: load set_val
set_val  in  NUM_CH*WIDTH  per-channel load value
clear  in  NUM_CH  per-channel: force counter to 0
dout  out  NUM_CH*WIDTH  per-channel counter value, delayed by LATENCY
ovf  out  NUM_CH  per-channel 1-cycle pulse: increment crossed 2^WIDTH-1 (wrapped or clamped), aligned with dout
unf  out  NUM_CH  per-channel 1-cycle pulse: decrement crossed 0, aligned with dout

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: rst=1 at an edge sets every counter, pipeline stage, dout, ovf and unf to 0, effective at that edge. Reset mid-operation flushes in-flight pipeline values; no stale value reaches dout after rst deasserts.
- Per-channel priority at each edge: clear > set_val_vld > inc/dec > hold.
- clear sets cnt=0 with no flags. set_val_vld sets cnt=set_val with no flags; inc/dec are ignored that cycle.
- inc and dec both high in the same cycle: net zero, cnt holds, no flags.
- inc only: sum = cnt + step (WIDTH+1 bits).
  - If sum > 2^WIDTH-1: CNT_WRAP gives cnt=sum mod 2^WIDTH; CNT_SAT gives cnt=2^WIDTH-1. Either way ovf=1.
- dec only: if step > cnt, CNT_WRAP gives cnt=(cnt-step) mod 2^WIDTH and CNT_SAT gives cnt=0. Either way unf=1.
- step=0 with inc or dec: cnt holds, no flags.
- CNT_SAT at the limit: inc at max gives ovf=1 every cycle; dec at 0 gives unf=1 every cycle.
- Latency:
  - The internal counter updates at edge t.
  - The new value plus its flags appear on dout/ovf/unf LATENCY-1 cycles after edge t (LATENCY=1: visible right after edge t).
  - Updates are not blocked: consecutive-cycle operations accumulate on the internal value, never on the delayed dout.
- Channels are fully independent. Simultaneous operations on different channels are all applied.
- Flags are registered and travel through the same delay line as dout.
- No handshake or backpressure; every cycle accepts an operation.

Decomposition:
- Package counter_pkg:
  - cnt_mode_e enum {CNT_WRAP, CNT_SAT}
  - cnt_op_e enum {OP_HOLD, OP_CLR, OP_SET, OP_INC, OP_DEC}, the priority-resolved per-channel operation
  - MAX_LATENCY=8 constant
- Sub-module counter_lane: one channel. It contains the op decode, the WIDTH+1 add/sub with wrap/sat, the counter register, and a LATENCY-deep delay line for {value, ovf, unf}.
- Top is a generate loop of NUM_CH counter_lane instances plus bus slicing.

Test Plan:
(All tests use NUM_CH=2, WIDTH=8, STEP_W=4, LATENCY=3, CNT_WRAP unless noted.)
1. Reset: drive ops, then rst=1 for 1 cycle -> dout=0, ovf=unf=0 on the next cycle and stay 0 until new ops propagate; a value in flight before reset never appears.
2. Back-to-back inc: ch0 inc step=1 for 5 consecutive cycles from 0 -> dout[ch0] shows 1,2,3,4,5 starting 2 cycles after the first edge; ch1 stays 0.
3. Wrap: ch0 set_val=0xFE, then inc step=3 -> dout=0x01 with ovf pulse in the same cycle. Then dec step=2 from 0x01 -> dout=0xFF with unf pulse.
4. Saturate (MODE=CNT_SAT): ch1 set_val=0xFD, inc step=5 -> dout=0xFF, ovf=1. A second inc -> 0xFF, ovf=1 again. Clear then dec step=1 -> 0x00, unf=1.
5. Priority: same cycle clear+set_val_vld(0x55)+inc -> 0. Next cycle set_val_vld(0x55)+inc step=2 -> 0x55. Next cycle inc+dec step=7 -> 0x55 with no flags.
6. LATENCY=1 sweep: repeat scenario 2 -> dout reflects each update immediately after its edge. Random ops on both channels are checked against a reference model delayed by LATENCY.
